segre_tl_stage: RTL and testbench
=================================

Name: segre_tl_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the execute result, register-file write info and memop controls.
- Performs data-memory loads and stores over a req/gnt/rvalid handshake, including byte-lane alignment and load sign/zero extension.
- Delivers a registered write-back record to the WB stage.
- Asserts hazard_o to stall upstream stages while a memory access is outstanding.

Parameters:
- ADDR_W, 32, width of the memory address bus (WORD_SIZE).
- DATA_W, 32, width of the memory data bus (WORD_SIZE).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rsn_i  in  1  reset; synchronous, active-high.
- alu_res_i  in  WORD_SIZE  ALU result; this is the effective address for memops.
- rf_we_i  in  1  register-file write enable.
- rf_waddr_i  in  REG_SIZE  destination register.
- rf_st_data_i  in  WORD_SIZE  store data.
- memop_type_i  in  memop_data_type_e  BYTE, HALF or WORD.
- memop_rd_i  in  1  load request.
- memop_wr_i  in  1  store request.
- memop_sign_ext_i  in  1  sign-extend load data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0).
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  DATA_W  lane-replicated store data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  DATA_W  load data.
- rf_we_o  out  1  WB write enable.
- rf_waddr_o  out  REG_SIZE  WB destination register.
- rf_data_o  out  WORD_SIZE  WB data.
- hazard_o  out  1  stall request to upstream stages (combinational).

Behaviour:
- Reset (rsn_i=1 at a clock edge):
  - state goes to IDLE.
  - All registered outputs clear: rf_we_o, rf_waddr_o, rf_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o all 0.
  - An outstanding access is abandoned. A late gnt or rvalid arriving in IDLE is ignored.
- FSM states: tl_state_e = {TL_IDLE, TL_REQ, TL_WAIT}.
- TL_IDLE, no memop (rd=wr=0):
  - Pass-through with 1-cycle latency: rf_we_o<=rf_we_i, rf_waddr_o<=rf_waddr_i, rf_data_o<=alu_res_i.
- TL_IDLE, memop (rd|wr):
  - Capture address, store data, type, sign_ext, waddr, rd/wr into internal registers.
  - Drive mem_* from the captured values (registered). Next state TL_REQ.
  - rf_we_o<=0.
- If rd and wr are both 1, treat the instruction as a store.
- TL_REQ:
  - mem_req_o=1, request held stable until mem_gnt_i=1.
  - On gnt with a store: done, next state TL_IDLE.
  - On gnt with a load: next state TL_WAIT, mem_req_o deasserts.
- TL_WAIT:
  - Wait for mem_rvalid_i. On rvalid: done, next state TL_IDLE.
  - rf_we_o<=1, rf_waddr_o<=captured waddr, rf_data_o<=extended load data.
  - rvalid in the same cycle as gnt is not supported; rvalid is sampled only in TL_WAIT.
- While busy and not done: rf_we_o<=0. Inputs from EX are ignored (they carry bubbles).
- hazard_o = (IDLE & (rd|wr)) | (state!=IDLE & !done).
  - hazard_o is low in the done cycle so EX advances in that same cycle.
  - Minimum load latency is 3 cycles (IDLE, REQ with gnt, WAIT with rvalid). Minimum store latency is 2 cycles.
- Byte enables (a = addr[1:0]):
  - BYTE: 4'b0001<<a.
  - HALF: 4'b0011<<(a[1]*2).
  - WORD: 4'b1111.
- Store data: BYTE replicates the byte ×4, HALF replicates the half ×2, WORD is unchanged.
- Load extract:
  - Shift: rdata>>(8*a) for BYTE, rdata>>(16*a[1]) for HALF.
  - Extend: width 8 or 16, sign- or zero-extended per the captured sign_ext. WORD is unchanged.

Optional Feature:
- Macro: SEGRE_TL_MISALIGN_CHECK_EN.
- With the macro defined:
  - A misaligned access is detected: HALF with a[0]=1, or WORD with a!=0.
  - No memory request is issued and the state stays TL_IDLE.
  - rf_we_o<=0 and hazard_o stays low.
  - Extra port misalign_o (out, 1) pulses 1 cycle, registered; it resets to 0.
- Without the macro:
  - misalign_o is absent.
  - Offending low address bits are masked (HALF uses a[1] only, WORD ignores a) and the access proceeds.

Decomposition:
- segre_pkg gains: tl_state_e, and constant MEM_BE_W=4. It already holds memop_data_type_e, WORD_SIZE and REG_SIZE.
- Combinational sub-module segre_lsu_align:
  - Inputs: type, addr[1:0], store data, rdata, sign_ext.
  - Outputs: be, wdata, load result.
- The FSM, capture registers and WB registers stay in segre_tl_stage.

Test Plan:
1. ALU op with rf_we_i=1, waddr=5, alu_res_i=0x1234, no memop -> next cycle rf_we_o=1, rf_waddr_o=5, rf_data_o=0x1234; hazard_o=0 throughout.
2. Word load at 0x100, gnt after 2 cycles, rvalid 1 cycle later with rdata 0xDEADBEEF -> mem_addr_o=0x100, be=0xF; hazard_o high until the rvalid cycle; rf_data_o=0xDEADBEEF with a single rf_we_o pulse.
3. Signed byte load at 0x103, rdata 0x80FFFFFF -> rf_data_o=0xFFFFFF80. Same access unsigned -> rf_data_o=0x00000080.
4. Half store at 0x102, data 0x0000ABCD, immediate gnt -> be=4'b1100, wdata=0xABCDABCD, mem_we_o=1; rf_we_o=0; hazard_o drops in the gnt cycle.
5. Load outstanding in TL_WAIT, then rsn_i=1 for 1 cycle -> all outputs 0, state TL_IDLE; a following rvalid produces no rf_we_o.
6. With SEGRE_TL_MISALIGN_CHECK_EN: word load at 0x102 -> mem_req_o stays 0, misalign_o=1 for 1 cycle, hazard_o=0.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre pipeline.
//   WORD_SIZE / REG_SIZE  : datapath and register-index widths
//   MEM_BE_W              : number of byte enables on the data-memory port
//   memop_data_type_e     : access width of a memop
//   tl_state_e            : TL stage FSM states
//   is_misaligned()       : true when an access does not fit its natural alignment
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned REG_SIZE  = 5;
  localparam int unsigned MEM_BE_W  = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    TL_IDLE = 2'b00,
    TL_REQ  = 2'b01,
    TL_WAIT = 2'b10
  } tl_state_e;

  function automatic logic is_misaligned(memop_data_type_e t, logic [1:0] a);
    return ((t == HALF) && a[0]) || ((t == WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/segre_lsu_align.sv
// Combinational byte-lane alignment for the TL stage.
//   type_i     : access width
//   addr_i     : low two bits of the effective address
//   st_data_i  : store data from the register file
//   rdata_i    : raw word returned by memory
//   sign_ext_i : sign-extend (1) or zero-extend (0) sub-word loads
//   be_o       : byte enables
//   wdata_o    : store data replicated across every lane it may occupy
//   ld_data_o  : load data shifted down and extended
// HALF only looks at addr_i[1] and WORD ignores addr_i, so misaligned bits are masked here.
module segre_lsu_align
  import segre_pkg::*;
(
  input  memop_data_type_e       type_i,
  input  logic [1:0]             addr_i,
  input  logic [WORD_SIZE-1:0]   st_data_i,
  input  logic [WORD_SIZE-1:0]   rdata_i,
  input  logic                   sign_ext_i,
  output logic [MEM_BE_W-1:0]    be_o,
  output logic [WORD_SIZE-1:0]   wdata_o,
  output logic [WORD_SIZE-1:0]   ld_data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign byte_sel = addr_i[0] ? half_sel[15:8] : half_sel[7:0];

  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = rdata_i;
    case (type_i)
      BYTE: begin
        be_o      = 4'b0001 << addr_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        be_o      = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
      end
      default: begin
        be_o      = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/segre_tl_stage.sv
// TL pipeline stage: sits after EX, performs data-memory loads/stores over a
// req/gnt/rvalid handshake and registers the write-back record for WB.
//   clk_i, rsn_i            : clock, synchronous active-high reset
//   alu_res_i .. memop_*    : instruction from EX (alu_res_i is the memop address)
//   mem_*_o / mem_*_i       : data-memory port (registered request side)
//   rf_we_o/waddr_o/data_o  : registered write-back record
//   hazard_o                : combinational stall request to upstream stages
// Optional build macro SEGRE_TL_MISALIGN_CHECK_EN: misaligned accesses are dropped and
// flagged on misalign_o (1-cycle registered pulse) instead of being masked.
module segre_tl_stage
  import segre_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic [WORD_SIZE-1:0]  alu_res_i,
  input  logic                  rf_we_i,
  input  logic [REG_SIZE-1:0]   rf_waddr_i,
  input  logic [WORD_SIZE-1:0]  rf_st_data_i,
  input  memop_data_type_e      memop_type_i,
  input  logic                  memop_rd_i,
  input  logic                  memop_wr_i,
  input  logic                  memop_sign_ext_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [MEM_BE_W-1:0]   mem_be_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  rf_we_o,
  output logic [REG_SIZE-1:0]   rf_waddr_o,
  output logic [WORD_SIZE-1:0]  rf_data_o,
`ifdef SEGRE_TL_MISALIGN_CHECK_EN
  output logic                  misalign_o,
`endif
  output logic                  hazard_o
);

  tl_state_e             state_q, state_d;
  logic                  is_memop, mis_det, accept, done;

  // Capture registers for the access in flight
  logic                  wr_q;
  memop_data_type_e      type_q;
  logic [1:0]            alo_q;
  logic                  sext_q;
  logic [REG_SIZE-1:0]   waddr_q;

  memop_data_type_e      al_type;
  logic [1:0]            al_addr;
  logic [MEM_BE_W-1:0]   al_be;
  logic [WORD_SIZE-1:0]  al_wdata, al_ld;

  assign is_memop = memop_rd_i | memop_wr_i;

`ifdef SEGRE_TL_MISALIGN_CHECK_EN
  assign mis_det = is_misaligned(memop_type_i, alu_res_i[1:0]);
`else
  assign mis_det = 1'b0;
`endif

  assign accept = (state_q == TL_IDLE) & is_memop & ~mis_det;

  // In IDLE the aligner prepares the request; once busy it works on the captured access.
  assign al_type = (state_q == TL_IDLE) ? memop_type_i : type_q;
  assign al_addr = (state_q == TL_IDLE) ? alu_res_i[1:0] : alo_q;

  segre_lsu_align u_align (
    .type_i     (al_type),
    .addr_i     (al_addr),
    .st_data_i  (rf_st_data_i),
    .rdata_i    (mem_rdata_i),
    .sign_ext_i (sext_q),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rsn_i) state_q <= TL_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      TL_IDLE: if (accept)       state_d = TL_REQ;
      TL_REQ:  if (mem_gnt_i)    state_d = wr_q ? TL_IDLE : TL_WAIT;
      TL_WAIT: if (mem_rvalid_i) state_d = TL_IDLE;
      default:                   state_d = TL_IDLE;
    endcase
  end

  // FSM outputs; hazard drops in the done cycle so EX advances on the same edge.
  always_comb begin
    done     = ((state_q == TL_REQ) & mem_gnt_i & wr_q) |
               ((state_q == TL_WAIT) & mem_rvalid_i);
    hazard_o = accept | ((state_q != TL_IDLE) & ~done);
  end

  // Memory port, capture and write-back registers
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_data_o   <= '0;
      wr_q        <= 1'b0;
      type_q      <= BYTE;
      alo_q       <= '0;
      sext_q      <= 1'b0;
      waddr_q     <= '0;
    end else begin
      case (state_q)
        TL_IDLE: begin
          if (accept) begin
            wr_q        <= memop_wr_i;
            type_q      <= memop_type_i;
            alo_q       <= alu_res_i[1:0];
            sext_q      <= memop_sign_ext_i;
            waddr_q     <= rf_waddr_i;
            mem_req_o   <= 1'b1;
            mem_we_o    <= memop_wr_i;
            mem_addr_o  <= {alu_res_i[ADDR_W-1:2], 2'b00};
            mem_be_o    <= al_be;
            mem_wdata_o <= al_wdata;
            rf_we_o     <= 1'b0;
          end else if (is_memop) begin
            rf_we_o <= 1'b0;
          end else begin
            rf_we_o    <= rf_we_i;
            rf_waddr_o <= rf_waddr_i;
            rf_data_o  <= alu_res_i;
          end
        end
        TL_REQ: begin
          rf_we_o <= 1'b0;
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
          end
        end
        TL_WAIT: begin
          rf_we_o <= mem_rvalid_i;
          if (mem_rvalid_i) begin
            rf_waddr_o <= waddr_q;
            rf_data_o  <= al_ld;
          end
        end
        default: rf_we_o <= 1'b0;
      endcase
    end
  end

`ifdef SEGRE_TL_MISALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rsn_i) misalign_o <= 1'b0;
    else       misalign_o <= (state_q == TL_IDLE) & is_memop & mis_det;
  end
`endif

endmodule

// File: tb/tb_segre_tl_stage.sv
module tb_segre_tl_stage;
  import segre_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rsn_i;
  logic [31:0]           alu_res_i;
  logic                  rf_we_i;
  logic [4:0]            rf_waddr_i;
  logic [31:0]           rf_st_data_i;
  memop_data_type_e      memop_type_i;
  logic                  memop_rd_i, memop_wr_i, memop_sign_ext_i;
  logic                  mem_req_o, mem_we_o;
  logic [31:0]           mem_addr_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_gnt_i, mem_rvalid_i;
  logic [31:0]           mem_rdata_i;
  logic                  rf_we_o;
  logic [4:0]            rf_waddr_o;
  logic [31:0]           rf_data_o;
  logic                  hazard_o;
`ifdef SEGRE_TL_MISALIGN_CHECK_EN
  logic                  misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  segre_tl_stage dut (
    .clk_i            (clk_i),
    .rsn_i            (rsn_i),
    .alu_res_i        (alu_res_i),
    .rf_we_i          (rf_we_i),
    .rf_waddr_i       (rf_waddr_i),
    .rf_st_data_i     (rf_st_data_i),
    .memop_type_i     (memop_type_i),
    .memop_rd_i       (memop_rd_i),
    .memop_wr_i       (memop_wr_i),
    .memop_sign_ext_i (memop_sign_ext_i),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_data_o        (rf_data_o),
`ifdef SEGRE_TL_MISALIGN_CHECK_EN
    .misalign_o       (misalign_o),
`endif
    .hazard_o         (hazard_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the access rules
  function automatic logic [31:0] m_be(memop_data_type_e t, int a);
    if (t == BYTE) return 32'd1 << a;
    if (t == HALF) return 32'd3 << (a & 2);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wd(memop_data_type_e t, logic [31:0] st);
    if (t == BYTE) return (st & 32'hFF) * 32'h0101_0101;
    if (t == HALF) return (st & 32'hFFFF) * 32'h0001_0001;
    return st;
  endfunction

  function automatic logic [31:0] m_ld(memop_data_type_e t, int a, logic [31:0] rd, logic sx);
    logic [31:0] v;
    if (t == BYTE) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (sx && v >= 32'd128) v = v - 32'd256;
    end else if (t == HALF) begin
      v = (rd >> (8 * (a & 2))) & 32'hFFFF;
      if (sx && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    memop_rd_i = 0; memop_wr_i = 0; rf_we_i = 0; alu_res_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  // Full memop from IDLE back to IDLE; called at posedge+1 with the stage idle.
  task automatic run_mem(input string tag, input logic rd, input logic wr,
                         input memop_data_type_e ty, input logic [31:0] addr,
                         input logic sext, input logic [31:0] st, input logic [31:0] rdat,
                         input int gd, input int rvd, input logic [31:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] eres);
    logic [4:0] wa;
    wa = 5'($urandom);
    memop_rd_i = rd; memop_wr_i = wr; memop_type_i = ty; alu_res_i = addr;
    memop_sign_ext_i = sext; rf_st_data_i = st; rf_waddr_i = wa; rf_we_i = 1;
    @(negedge clk_i) chk({tag, " hazard_issue"}, {31'b0, hazard_o}, 1);
    @(posedge clk_i) #1;
    // Bubbles from EX while busy; must be ignored
    memop_rd_i = 0; memop_wr_i = 0; rf_we_i = 1; rf_waddr_i = ~wa; alu_res_i = $urandom;
    memop_type_i = memop_data_type_e'($urandom_range(0, 2)); rf_st_data_i = $urandom;
    memop_sign_ext_i = ~sext;
    chk({tag, " req"}, {31'b0, mem_req_o}, 1);
    chk({tag, " we"}, {31'b0, mem_we_o}, {31'b0, wr});
    chk({tag, " addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
    chk({tag, " be"}, {28'b0, mem_be_o}, ebe);
    if (wr) chk({tag, " wdata"}, mem_wdata_o, ewd);
    chk({tag, " rf_we_busy"}, {31'b0, rf_we_o}, 0);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk_i) chk({tag, " hazard_req"}, {31'b0, hazard_o}, 1);
      @(posedge clk_i) #1 chk({tag, " req_hold"}, {31'b0, mem_req_o}, 1);
    end
    mem_gnt_i = 1;
    @(negedge clk_i) chk({tag, " hazard_gnt"}, {31'b0, hazard_o}, {31'b0, ~wr});
    @(posedge clk_i) #1;
    mem_gnt_i = 0;
    chk({tag, " req_drop"}, {31'b0, mem_req_o}, 0);
    chk({tag, " rf_we_gnt"}, {31'b0, rf_we_o}, 0);
    if (!wr) begin
      for (int i = 0; i < rvd; i++) begin
        @(negedge clk_i) chk({tag, " hazard_wait"}, {31'b0, hazard_o}, 1);
        @(posedge clk_i) #1 chk({tag, " rf_we_wait"}, {31'b0, rf_we_o}, 0);
      end
      mem_rvalid_i = 1; mem_rdata_i = rdat;
      @(negedge clk_i) chk({tag, " hazard_rvalid"}, {31'b0, hazard_o}, 0);
      @(posedge clk_i) #1;
      mem_rvalid_i = 0; mem_rdata_i = $urandom;
      chk({tag, " rf_we_wb"}, {31'b0, rf_we_o}, 1);
      chk({tag, " rf_waddr_wb"}, {27'b0, rf_waddr_o}, {27'b0, wa});
      chk({tag, " rf_data_wb"}, rf_data_o, eres);
    end
    rf_we_i = 0; alu_res_i = 0;
    @(posedge clk_i) #1 chk({tag, " rf_we_after"}, {31'b0, rf_we_o}, 0);
  endtask

  typedef struct {
    string            tag;
    logic             rd, wr;
    memop_data_type_e ty;
    logic [31:0]      addr;
    logic             sext;
    logic [31:0]      st, rdat;
    int               gd, rvd;
    logic [31:0]      be, wd, res;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rsn_i = 1; idle_inputs(); rf_waddr_i = 0; rf_st_data_i = 0; memop_type_i = BYTE;
    memop_sign_ext_i = 0; mem_rdata_i = 0;

    vecs.push_back('{"lw100", 1, 0, WORD, 32'h100, 0, 0, 32'hDEADBEEF, 2, 0, 4'hF, 0, 32'hDEADBEEF});
    vecs.push_back('{"lbs103", 1, 0, BYTE, 32'h103, 1, 0, 32'h80FFFFFF, 0, 0, 4'h8, 0, 32'hFFFFFF80});
    vecs.push_back('{"lbu103", 1, 0, BYTE, 32'h103, 0, 0, 32'h80FFFFFF, 1, 1, 4'h8, 0, 32'h00000080});
    vecs.push_back('{"sh102", 0, 1, HALF, 32'h102, 0, 32'h0000ABCD, 0, 0, 0, 4'hC, 32'hABCDABCD, 0});
    vecs.push_back('{"sb101", 0, 1, BYTE, 32'h101, 0, 32'h12345677, 0, 2, 0, 4'h2, 32'h77777777, 0});
    vecs.push_back('{"lhs100", 1, 0, HALF, 32'h100, 1, 0, 32'h12348001, 0, 2, 4'h3, 0, 32'hFFFF8001});
    vecs.push_back('{"lhu102", 1, 0, HALF, 32'h102, 0, 0, 32'hF00D1234, 0, 0, 4'hC, 0, 32'h0000F00D});
    vecs.push_back('{"rdwr_sw", 1, 1, WORD, 32'h204, 0, 32'hCAFEBABE, 0, 1, 0, 4'hF, 32'hCAFEBABE, 0});
    vecs.push_back('{"lw0", 1, 0, WORD, 32'h0, 0, 0, 32'h0BADF00D, 0, 3, 4'hF, 0, 32'h0BADF00D});
`ifndef SEGRE_TL_MISALIGN_CHECK_EN
    vecs.push_back('{"lh103m", 1, 0, HALF, 32'h103, 1, 0, 32'hABCD0000, 0, 0, 4'hC, 0, 32'hFFFFABCD});
    vecs.push_back('{"sw101m", 0, 1, WORD, 32'h101, 0, 32'h11223344, 0, 0, 0, 4'hF, 32'h11223344, 0});
`endif

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst req", {31'b0, mem_req_o}, 0);
    chk("rst rf_we", {31'b0, rf_we_o}, 0);
    chk("rst addr", mem_addr_o, 0);
    chk("rst be", {28'b0, mem_be_o}, 0);
    chk("rst hazard", {31'b0, hazard_o}, 0);
    rsn_i = 0;

    // ALU pass-through
    rf_we_i = 1; rf_waddr_i = 5; alu_res_i = 32'h1234;
    @(negedge clk_i) chk("pt hazard", {31'b0, hazard_o}, 0);
    @(posedge clk_i) #1;
    chk("pt rf_we", {31'b0, rf_we_o}, 1);
    chk("pt waddr", {27'b0, rf_waddr_o}, 5);
    chk("pt data", rf_data_o, 32'h1234);
    idle_inputs();
    @(posedge clk_i) #1;

    foreach (vecs[k])
      run_mem(vecs[k].tag, vecs[k].rd, vecs[k].wr, vecs[k].ty, vecs[k].addr, vecs[k].sext,
              vecs[k].st, vecs[k].rdat, vecs[k].gd, vecs[k].rvd, vecs[k].be, vecs[k].wd,
              vecs[k].res);

    // Reset while a load waits for rvalid
    memop_rd_i = 1; memop_type_i = WORD; alu_res_i = 32'h40; rf_waddr_i = 7;
    @(posedge clk_i) #1;
    memop_rd_i = 0; mem_gnt_i = 1;
    @(posedge clk_i) #1;
    mem_gnt_i = 0; rsn_i = 1;
    @(posedge clk_i) #1;
    rsn_i = 0;
    chk("rstw req", {31'b0, mem_req_o}, 0);
    chk("rstw addr", mem_addr_o, 0);
    chk("rstw rf_we", {31'b0, rf_we_o}, 0);
    chk("rstw hazard", {31'b0, hazard_o}, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h5555AAAA; rf_we_i = 0; alu_res_i = 0;
    @(posedge clk_i) #1;
    mem_rvalid_i = 0;
    chk("late rvalid rf_we", {31'b0, rf_we_o}, 0);
    chk("late rvalid data", rf_data_o, 0);
    chk("late rvalid req", {31'b0, mem_req_o}, 0);

`ifdef SEGRE_TL_MISALIGN_CHECK_EN
    memop_rd_i = 1; memop_type_i = WORD; alu_res_i = 32'h102; rf_we_i = 1;
    @(negedge clk_i) chk("mis hazard", {31'b0, hazard_o}, 0);
    @(posedge clk_i) #1;
    idle_inputs();
    chk("mis pulse", {31'b0, misalign_o}, 1);
    chk("mis req", {31'b0, mem_req_o}, 0);
    chk("mis rf_we", {31'b0, rf_we_o}, 0);
    @(posedge clk_i) #1;
    chk("mis pulse end", {31'b0, misalign_o}, 0);
    chk("mis req2", {31'b0, mem_req_o}, 0);
`endif

    // Randomised traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, st, rd;
      memop_data_type_e ty;
      logic wr, sx;
      a = $urandom; st = $urandom; rd = $urandom;
      ty = memop_data_type_e'($urandom_range(0, 2));
      wr = 1'($urandom); sx = 1'($urandom);
`ifdef SEGRE_TL_MISALIGN_CHECK_EN
      if (ty == HALF) a[0] = 0;
      if (ty == WORD) a[1:0] = 0;
`endif
      if ($urandom_range(0, 3) == 0) begin
        logic [4:0] wa;
        wa = 5'($urandom);
        rf_we_i = 1'($urandom); rf_waddr_i = wa; alu_res_i = a;
        @(negedge clk_i) chk("rpt hazard", {31'b0, hazard_o}, 0);
        @(posedge clk_i) #1;
        chk("rpt rf_we", {31'b0, rf_we_o}, {31'b0, rf_we_i});
        chk("rpt waddr", {27'b0, rf_waddr_o}, {27'b0, wa});
        chk("rpt data", rf_data_o, a);
        idle_inputs();
      end else begin
        run_mem("rnd", ~wr | 1'($urandom), wr, ty, a, sx, st, rd, $urandom_range(0, 2),
                $urandom_range(0, 2), m_be(ty, int'(a[1:0])), m_wd(ty, st),
                m_ld(ty, int'(a[1:0]), rd, sx));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
